// File: rtl/cordic_arbiter_if.sv
// Request, response and shared-core bus of the two-requester CORDIC arbiter.
// slave is the arbiter side; master is the requester/core side.
interface cordic_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_mode;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic [WIDTH-1:0] req0_z;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_mode;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic [WIDTH-1:0] req1_z;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_res1;
  logic [WIDTH-1:0] rsp0_res2;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_res1;
  logic [WIDTH-1:0] rsp1_res2;
  logic             core_mode;
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_z;
  logic [WIDTH-1:0] core_res1;
  logic [WIDTH-1:0] core_res2;

  modport slave (
    input  req0_valid, req0_mode,
    input  req0_x, req0_y, req0_z,
    output req0_ready,
    input  req1_valid, req1_mode,
    input  req1_x, req1_y, req1_z,
    output req1_ready,
    output rsp0_valid, rsp0_res1, rsp0_res2,
    input  rsp0_ready,
    output rsp1_valid, rsp1_res1, rsp1_res2,
    input  rsp1_ready,
    output core_mode, core_x, core_y, core_z,
    input  core_res1, core_res2
  );

  modport master (
    output req0_valid, req0_mode,
    output req0_x, req0_y, req0_z,
    input  req0_ready,
    output req1_valid, req1_mode,
    output req1_x, req1_y, req1_z,
    input  req1_ready,
    input  rsp0_valid, rsp0_res1, rsp0_res2,
    output rsp0_ready,
    input  rsp1_valid, rsp1_res1, rsp1_res2,
    output rsp1_ready,
    input  core_mode, core_x, core_y, core_z,
    output core_res1, core_res2
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Two-requester arbiter in front of one pipelined CORDIC core, with
// credit-reserved result FIFOs. CORDIC_ARB_FIXED_PRIO_EN: req0 strict priority.
module cordic_arbiter #(
  parameter int WIDTH      = 16,
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  cordic_arbiter_if.slave bus,
  output logic            idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]         valid;
  logic [1:0]         rsp_rdy;
  logic [1:0]         elig;
  logic [1:0]         gnt;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic               issue;
  logic               run;
  logic               pres_v;
  logic               pres_id;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;
  logic [CW-1:0]      count [2];
  logic [CW-1:0]      infl [2];
  logic [AW-1:0]      wr_ptr [2];
  logic [AW-1:0]      rd_ptr [2];
  logic [2*WIDTH-1:0] mem [2][FIFO_DEPTH];

  assign valid   = {bus.req1_valid, bus.req0_valid};
  assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
  assign issue   = |gnt;

  // Jobs between issue and FIFO push, per requester.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      infl[n] = '0;
      if (pres_v && pres_id == 1'(n))
        infl[n] = infl[n] + ONE;
      for (int k = 0; k < LATENCY; k++)
        if (tag_v[k] && tag_id[k] == 1'(n))
          infl[n] = infl[n] + ONE;
    end
  end

  // A requester is eligible while its FIFO has unreserved space.
  always_comb begin
    for (int n = 0; n < 2; n++)
      elig[n] = valid[n] && run &&
                (count[n] + infl[n] < DEPTH_C);
  end

`ifdef CORDIC_ARB_FIXED_PRIO_EN
  // req0 wins whenever it is eligible.
  always_comb begin
    gnt[0] = elig[0];
    gnt[1] = elig[1] & ~elig[0];
  end
`else
  logic last;

  // On a tie the requester not issued last wins.
  always_comb begin
    gnt[0] = elig[0] & (~elig[1] | last);
    gnt[1] = elig[1] & (~elig[0] | ~last);
  end

  // Round-robin pointer moves only on an issue; reset favours req0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last <= 1'b1;
    else if (issue)
      last <= gnt[1];
  end
`endif

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  // Issues are blocked until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      run <= 1'b0;
    else
      run <= 1'b1;
  end

  // Register the granted operands; hold them when nothing issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.core_mode <= 1'b0;
      bus.core_x    <= '0;
      bus.core_y    <= '0;
      bus.core_z    <= '0;
      pres_v        <= 1'b0;
      pres_id       <= 1'b0;
    end else begin
      pres_v  <= issue;
      pres_id <= gnt[1];
      unique case (1'b1)
        gnt[0]: begin
          bus.core_mode <= bus.req0_mode;
          bus.core_x    <= bus.req0_x;
          bus.core_y    <= bus.req0_y;
          bus.core_z    <= bus.req0_z;
        end
        gnt[1]: begin
          bus.core_mode <= bus.req1_mode;
          bus.core_x    <= bus.req1_x;
          bus.core_y    <= bus.req1_y;
          bus.core_z    <= bus.req1_z;
        end
        default: ;
      endcase
    end
  end

  // Tag pipe follows the presented operands through the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= pres_v;
      tag_id[0] <= pres_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // The last tag stage lines up with the core result for its job.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      push[n] = tag_v[LATENCY-1] &&
                tag_id[LATENCY-1] == 1'(n);
      pop[n]  = (count[n] != '0) && rsp_rdy[n];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n])
          wr_ptr[n] <= wr_ptr[n] + AW'(1);
        if (pop[n])
          rd_ptr[n] <= rd_ptr[n] + AW'(1);
        count[n] <= count[n]
                  + (push[n] ? ONE : '0)
                  - (pop[n] ? ONE : '0);
      end
    end
  end

  // Result storage; contents are qualified by count, so no reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++)
      if (push[n])
        mem[n][wr_ptr[n]] <= {bus.core_res1, bus.core_res2};
  end

  assign bus.rsp0_valid = count[0] != '0;
  assign bus.rsp1_valid = count[1] != '0;
  assign bus.rsp0_res1  = mem[0][rd_ptr[0]][2*WIDTH-1:WIDTH];
  assign bus.rsp0_res2  = mem[0][rd_ptr[0]][WIDTH-1:0];
  assign bus.rsp1_res1  = mem[1][rd_ptr[1]][2*WIDTH-1:WIDTH];
  assign bus.rsp1_res2  = mem[1][rd_ptr[1]][WIDTH-1:0];

  assign idle = ~pres_v && ~|tag_v &&
                count[0] == '0 && count[1] == '0;

endmodule
